ysyx_22041207_trap_ctrl: RTL and testbench

//  Trap/return sequencer for the multi-cycle core. Sits between the writeback stage and the CSR file.
//  At writeback (stage==3'h4) it arbitrates ecall / illegal-instruction / timer-interrupt / mret and

---
 rtl/ysyx_22041207_trap_ctrl_if.sv | 20 ++
 rtl/ysyx_22041207_trap_ctrl.sv | 161 ++++++++++++++++
 tb/tb_ysyx_22041207_trap_ctrl.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_22041207_trap_ctrl_if.sv
// Redirect handshake between the trap sequencer (master) and the fetch unit (slave).
interface ysyx_22041207_trap_ctrl_if #(
    parameter int XLEN = 64
);
    logic            redir_valid;
    logic [XLEN-1:0] redir_pc;
    logic            redir_ready;

    modport master (
        output redir_valid,
        output redir_pc,
        input  redir_ready
    );

    modport slave (
        input  redir_valid,
        input  redir_pc,
        output redir_ready
    );
endinterface

// File: rtl/ysyx_22041207_trap_ctrl.sv
// Trap / mret sequencer between writeback and the CSR file.
// Arbitrates irq > illegal > ecall > mret at writeback, pulses the CSR write
// strobes for one cycle, then offers the redirect PC to fetch over a
// valid/ready handshake. All outputs are registered and decoded from the next state.
module ysyx_22041207_trap_ctrl #(
    parameter int XLEN     = 64,
    parameter int IRQ_CODE = 7
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [2:0]                  stage,
    input  logic [XLEN-1:0]             pc,
    input  logic [XLEN-1:0]             npc,
    input  logic                        is_ecall,
    input  logic                        is_illegal,
    input  logic                        is_mret,
    input  logic                        irq_timer,
    input  logic                        mstatus_mie,
    input  logic [XLEN-1:0]             mtvec_i,
    input  logic [XLEN-1:0]             mepc_i,
    output logic                        wmepc,
    output logic [XLEN-1:0]             mepc_v,
    output logic                        wmcause,
    output logic [XLEN-1:0]             mcause_v,
    output logic                        trap_enter,
    output logic                        mret_commit,
    output logic                        stall,
    ysyx_22041207_trap_ctrl_if.master   redir
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SAVE  = 2'd1,
        MRET  = 2'd2,
        REDIR = 2'd3
    } state_t;

    localparam logic [XLEN-1:0] IRQ_CAUSE     = {1'b1, (XLEN-1)'(IRQ_CODE)};
    localparam logic [XLEN-1:0] ILLEGAL_CAUSE = XLEN'(2);
    localparam logic [XLEN-1:0] ECALL_CAUSE   = XLEN'(11);

    // Trap vector: vectored mode only offsets interrupts; the interrupt bit
    // falls off the top of the shift, leaving base + 4*code (mod 2^XLEN).
    function automatic logic [XLEN-1:0] vec_target(input logic [XLEN-1:0] mtvec,
                                                   input logic [XLEN-1:0] cause);
        logic [XLEN-1:0] base;
        base = {mtvec[XLEN-1:2], 2'b00};
        if (mtvec[1:0] == 2'b01 && cause[XLEN-1]) begin
            return base + (cause << 2);
        end else begin
            return base;
        end
    endfunction

    state_t          state_r, state_s;
    logic [XLEN-1:0] cause_r, cause_s;
    logic [XLEN-1:0] epc_r, epc_s;
    logic [XLEN-1:0] target_r, target_s;
    logic            irq_s;

    logic            wmepc_r, wmcause_r, trap_enter_r, mret_commit_r, stall_r;
    logic            redir_valid_r;
    logic [XLEN-1:0] mepc_v_r, mcause_v_r, redir_pc_r;

    // Next-state logic: event arbitration in IDLE, target capture in SAVE, handshake in REDIR.
    always_comb begin
        state_s  = state_r;
        cause_s  = cause_r;
        epc_s    = epc_r;
        target_s = target_r;
        irq_s    = irq_timer & mstatus_mie;
        case (state_r)
            IDLE: begin
                if (stage == 3'h4) begin
                    if (irq_s) begin
                        state_s = SAVE;
                        cause_s = IRQ_CAUSE;
                        // A trapping instruction does not commit, so it is re-run on return.
                        epc_s   = (is_illegal | is_ecall) ? pc : npc;
                    end else if (is_illegal) begin
                        state_s = SAVE;
                        cause_s = ILLEGAL_CAUSE;
                        epc_s   = pc;
                    end else if (is_ecall) begin
                        state_s = SAVE;
                        cause_s = ECALL_CAUSE;
                        epc_s   = pc;
                    end else if (is_mret) begin
                        state_s  = MRET;
                        target_s = mepc_i;
                    end else begin
                        state_s = IDLE;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            SAVE: begin
                target_s = vec_target(mtvec_i, cause_r);
                state_s  = REDIR;
            end
            MRET: begin
                state_s = REDIR;
            end
            REDIR: begin
                if (redir.redir_ready) begin
                    state_s = IDLE;
                end else begin
                    state_s = REDIR;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State, internal capture registers and Moore outputs decoded from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= IDLE;
            cause_r       <= '0;
            epc_r         <= '0;
            target_r      <= '0;
            wmepc_r       <= 1'b0;
            wmcause_r     <= 1'b0;
            trap_enter_r  <= 1'b0;
            mret_commit_r <= 1'b0;
            stall_r       <= 1'b0;
            redir_valid_r <= 1'b0;
            mepc_v_r      <= '0;
            mcause_v_r    <= '0;
            redir_pc_r    <= '0;
        end else begin
            state_r       <= state_s;
            cause_r       <= cause_s;
            epc_r         <= epc_s;
            target_r      <= target_s;
            wmepc_r       <= (state_s == SAVE);
            wmcause_r     <= (state_s == SAVE);
            trap_enter_r  <= (state_s == SAVE);
            mret_commit_r <= (state_s == MRET);
            stall_r       <= (state_s != IDLE);
            redir_valid_r <= (state_s == REDIR);
            mepc_v_r      <= (state_s == SAVE)  ? epc_s    : '0;
            mcause_v_r    <= (state_s == SAVE)  ? cause_s  : '0;
            redir_pc_r    <= (state_s == REDIR) ? target_s : '0;
        end
    end

    assign wmepc             = wmepc_r;
    assign wmcause           = wmcause_r;
    assign trap_enter        = trap_enter_r;
    assign mret_commit       = mret_commit_r;
    assign stall             = stall_r;
    assign mepc_v            = mepc_v_r;
    assign mcause_v          = mcause_v_r;
    assign redir.redir_valid = redir_valid_r;
    assign redir.redir_pc    = redir_pc_r;

endmodule

// File: tb/tb_ysyx_22041207_trap_ctrl.sv
// Directed bench for the trap/return sequencer: vector table plus hand-written
// sequences for back-pressure and mid-sequence reset.
module tb_ysyx_22041207_trap_ctrl;

    logic        clk;
    logic        rst;
    logic [2:0]  stage;
    logic [63:0] pc, npc, mtvec_i, mepc_i;
    logic        is_ecall, is_illegal, is_mret, irq_timer, mstatus_mie;
    logic        wmepc, wmcause, trap_enter, mret_commit, stall;
    logic [63:0] mepc_v, mcause_v;

    int pass_cnt;
    int total_cnt;

    ysyx_22041207_trap_ctrl_if #(.XLEN(64)) rif ();

    ysyx_22041207_trap_ctrl #(.XLEN(64), .IRQ_CODE(7)) dut (
        .clk         (clk),
        .rst         (rst),
        .stage       (stage),
        .pc          (pc),
        .npc         (npc),
        .is_ecall    (is_ecall),
        .is_illegal  (is_illegal),
        .is_mret     (is_mret),
        .irq_timer   (irq_timer),
        .mstatus_mie (mstatus_mie),
        .mtvec_i     (mtvec_i),
        .mepc_i      (mepc_i),
        .wmepc       (wmepc),
        .mepc_v      (mepc_v),
        .wmcause     (wmcause),
        .mcause_v    (mcause_v),
        .trap_enter  (trap_enter),
        .mret_commit (mret_commit),
        .stall       (stall),
        .redir       (rif.master)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  stage;
        logic [63:0] pc;
        logic [63:0] npc;
        logic        ecall;
        logic        illegal;
        logic        mret;
        logic        irq;
        logic        mie;
        logic [63:0] mtvec;
        logic [63:0] mepc;
        logic        exp_resp;
        logic        exp_trap;
        logic        exp_mret;
        logic [63:0] exp_cause;
        logic [63:0] exp_epc;
        logic [63:0] exp_pc;
    } vec_t;

    vec_t vecs [10];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic clear_events();
        stage      = 3'h0;
        is_ecall   = 1'b0;
        is_illegal = 1'b0;
        is_mret    = 1'b0;
        irq_timer  = 1'b0;
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_wmepc"},       64'(wmepc),           64'h0);
        chk({tag, "_wmcause"},     64'(wmcause),         64'h0);
        chk({tag, "_trap_enter"},  64'(trap_enter),      64'h0);
        chk({tag, "_mret_commit"}, 64'(mret_commit),     64'h0);
        chk({tag, "_stall"},       64'(stall),           64'h0);
        chk({tag, "_redir_valid"}, 64'(rif.redir_valid), 64'h0);
        chk({tag, "_redir_pc"},    rif.redir_pc,         64'h0);
        chk({tag, "_mepc_v"},      mepc_v,               64'h0);
        chk({tag, "_mcause_v"},    mcause_v,             64'h0);
    endtask

    // One event at cycle N, strobes checked at N+1, redirect at N+2, accept, back to idle.
    task automatic run_vec(input int idx, input vec_t v);
        string t;
        t = $sformatf("v%0d", idx);
        stage       = v.stage;
        pc          = v.pc;
        npc         = v.npc;
        is_ecall    = v.ecall;
        is_illegal  = v.illegal;
        is_mret     = v.mret;
        irq_timer   = v.irq;
        mstatus_mie = v.mie;
        mtvec_i     = v.mtvec;
        mepc_i      = v.mepc;
        tick();
        clear_events();
        chk({t, "_wmepc"},       64'(wmepc),       64'(v.exp_trap));
        chk({t, "_wmcause"},     64'(wmcause),     64'(v.exp_trap));
        chk({t, "_trap_enter"},  64'(trap_enter),  64'(v.exp_trap));
        chk({t, "_mret_commit"}, 64'(mret_commit), 64'(v.exp_mret));
        chk({t, "_stall"},       64'(stall),       64'(v.exp_resp));
        if (v.exp_trap) begin
            chk({t, "_mepc_v"},   mepc_v,   v.exp_epc);
            chk({t, "_mcause_v"}, mcause_v, v.exp_cause);
        end
        tick();
        chk({t, "_redir_valid"}, 64'(rif.redir_valid), 64'(v.exp_resp));
        chk({t, "_wmepc_1cyc"},  64'(wmepc),           64'h0);
        chk({t, "_mret_1cyc"},   64'(mret_commit),     64'h0);
        if (v.exp_resp) begin
            chk({t, "_redir_pc"}, rif.redir_pc, v.exp_pc);
            rif.redir_ready = 1'b1;
            tick();
            rif.redir_ready = 1'b0;
            chk({t, "_done_valid"}, 64'(rif.redir_valid), 64'h0);
            chk({t, "_done_stall"}, 64'(stall),           64'h0);
        end
    endtask

    initial begin
        pass_cnt        = 0;
        total_cnt       = 0;
        clk             = 1'b0;
        rst             = 1'b1;
        pc              = 64'h0;
        npc             = 64'h0;
        mtvec_i         = 64'h0;
        mepc_i          = 64'h0;
        mstatus_mie     = 1'b0;
        rif.redir_ready = 1'b0;
        clear_events();

        //          stage  pc                     npc                    ec    il    mr    irq   mie   mtvec                  mepc                   resp  trap  mret  cause                  epc                    redir_pc
        vecs[0] = '{3'h4, 64'h0000_0000_8000_0010, 64'h0000_0000_8000_0014, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0000_0000_8000_1000, 64'h0,                 1'b1, 1'b1, 1'b0, 64'd11,                64'h0000_0000_8000_0010, 64'h0000_0000_8000_1000};
        vecs[1] = '{3'h4, 64'h0000_0000_8000_0020, 64'h0000_0000_8000_0024, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 64'h0000_0000_8000_1001, 64'h0,                 1'b1, 1'b1, 1'b0, 64'h8000_0000_0000_0007, 64'h0000_0000_8000_0024, 64'h0000_0000_8000_101C};
        vecs[2] = '{3'h4, 64'h0000_0000_8000_0030, 64'h0000_0000_8000_0034, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 64'h0000_0000_8000_1000, 64'h0000_0000_8000_0014, 1'b1, 1'b0, 1'b1, 64'h0,                64'h0,                 64'h0000_0000_8000_0014};
        vecs[3] = '{3'h4, 64'h0000_0000_8000_0100, 64'h0000_0000_8000_0104, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 64'h0000_0000_8000_1001, 64'h0,                 1'b1, 1'b1, 1'b0, 64'd11,                64'h0000_0000_8000_0100, 64'h0000_0000_8000_1000};
        vecs[4] = '{3'h4, 64'h0000_0000_8000_0200, 64'h0000_0000_8000_0204, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 64'h0000_0000_8000_1001, 64'h0,                 1'b1, 1'b1, 1'b0, 64'h8000_0000_0000_0007, 64'h0000_0000_8000_0200, 64'h0000_0000_8000_101C};
        vecs[5] = '{3'h4, 64'h0000_0000_8000_0300, 64'h0000_0000_8000_0304, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 64'h0000_0000_8000_2003, 64'h0,                 1'b1, 1'b1, 1'b0, 64'd2,                 64'h0000_0000_8000_0300, 64'h0000_0000_8000_2000};
        vecs[6] = '{3'h3, 64'h0000_0000_8000_0400, 64'h0000_0000_8000_0404, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 64'h0000_0000_8000_1000, 64'h0,                 1'b0, 1'b0, 1'b0, 64'h0,                64'h0,                 64'h0};
        vecs[7] = '{3'h4, 64'h0000_0000_8000_0500, 64'h0000_0000_8000_0504, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 64'h0000_0000_8000_1000, 64'h0,                 1'b0, 1'b0, 1'b0, 64'h0,                64'h0,                 64'h0};
        vecs[8] = '{3'h4, 64'h0000_0000_8000_0600, 64'h0000_0000_8000_0604, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 64'h0000_0000_8000_3000, 64'h0000_0000_8000_0F00, 1'b1, 1'b1, 1'b0, 64'd11,                64'h0000_0000_8000_0600, 64'h0000_0000_8000_3000};
        vecs[9] = '{3'h4, 64'h0000_0000_8000_0700, 64'h0000_0000_8000_0704, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFF1, 64'h0,                 1'b1, 1'b1, 1'b0, 64'h8000_0000_0000_0007, 64'h0000_0000_8000_0704, 64'h0000_0000_0000_000C};

        // Reset state, with an event presented during reset that must be ignored.
        stage    = 3'h4;
        is_ecall = 1'b1;
        tick();
        tick();
        chk_quiet("reset");
        clear_events();
        rst = 1'b0;
        tick();
        chk_quiet("post_reset");

        for (int i = 0; i < 10; i++) begin
            run_vec(i, vecs[i]);
        end

        // Back-pressure: redirect held for 5 cycles, new events ignored meanwhile.
        mtvec_i  = 64'h0000_0000_8000_1000;
        pc       = 64'h0000_0000_8000_0800;
        stage    = 3'h4;
        is_ecall = 1'b1;
        tick();
        clear_events();
        tick();
        stage       = 3'h4;
        is_illegal  = 1'b1;
        irq_timer   = 1'b1;
        mstatus_mie = 1'b1;
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("hold%0d_valid", k), 64'(rif.redir_valid), 64'h1);
            chk($sformatf("hold%0d_pc", k),    rif.redir_pc,         64'h0000_0000_8000_1000);
            chk($sformatf("hold%0d_stall", k), 64'(stall),           64'h1);
            chk($sformatf("hold%0d_wmepc", k), 64'(wmepc),           64'h0);
            tick();
        end
        clear_events();
        rif.redir_ready = 1'b1;
        tick();
        rif.redir_ready = 1'b0;
        chk("hold_done_valid", 64'(rif.redir_valid), 64'h0);
        chk("hold_done_stall", 64'(stall),           64'h0);

        // Reset while in SAVE.
        stage    = 3'h4;
        is_ecall = 1'b1;
        tick();
        clear_events();
        chk("rsave_pre_wmepc", 64'(wmepc), 64'h1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_quiet("rst_in_save");
        tick();
        chk_quiet("rst_in_save_idle");

        // Reset while in REDIR.
        stage    = 3'h4;
        is_ecall = 1'b1;
        tick();
        clear_events();
        tick();
        chk("rredir_pre_valid", 64'(rif.redir_valid), 64'h1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_quiet("rst_in_redir");

        // Fresh ecall after the aborted sequence.
        run_vec(10, vecs[0]);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
